// File: rtl/mem_lsu.sv
// mem_lsu: memory-access pipeline stage between ex_mem and mem_wb.
//   Forwards register and HI/LO write-back fields. Executes byte/halfword/word
//   loads and stores over a req/ack data bus and holds the pipeline with
//   stallreq_o until the access completes or times out. Misaligned accesses
//   are flagged on addr_err_o and never reach the bus.
// Ports:
//   clk, rst (synchronous, active-low)
//   wd_i/wreg_i/wdata_i/hi_i/lo_i/whilo_i   write-back fields from EX
//   aluop_i, mem_addr_i, reg2_i             operation, effective address, store data
//   wd_o/wreg_o/wdata_o/hi_o/lo_o/whilo_o   final write-back fields
//   mem_req_o/mem_we_o/mem_addr_o/mem_sel_o/mem_data_o   bus request side
//   mem_data_i/mem_ack_i                    bus response side
//   stallreq_o                              stall request to ctrl
//   addr_err_o                              misaligned access (combinational)
//   bus_err_o                               one-cycle pulse in DONE after a timeout
module mem_lsu #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 255,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    wd_i,
  input  logic          wreg_i,
  input  logic [31:0]   wdata_i,
  input  logic [31:0]   hi_i,
  input  logic [31:0]   lo_i,
  input  logic          whilo_i,
  input  logic [7:0]    aluop_i,
  input  logic [AW-1:0] mem_addr_i,
  input  logic [31:0]   reg2_i,
  output logic [4:0]    wd_o,
  output logic          wreg_o,
  output logic [31:0]   wdata_o,
  output logic [31:0]   hi_o,
  output logic [31:0]   lo_o,
  output logic          whilo_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [3:0]    mem_sel_o,
  output logic [31:0]   mem_data_o,
  input  logic [31:0]   mem_data_i,
  input  logic          mem_ack_i,
  output logic          stallreq_o,
  output logic          addr_err_o,
  output logic          bus_err_o
);

  localparam logic [7:0] EXE_LB_OP  = 8'b11100000;
  localparam logic [7:0] EXE_LBU_OP = 8'b11100100;
  localparam logic [7:0] EXE_LH_OP  = 8'b11100001;
  localparam logic [7:0] EXE_LHU_OP = 8'b11100101;
  localparam logic [7:0] EXE_LW_OP  = 8'b11100011;
  localparam logic [7:0] EXE_SB_OP  = 8'b11101000;
  localparam logic [7:0] EXE_SH_OP  = 8'b11101001;
  localparam logic [7:0] EXE_SW_OP  = 8'b11101011;
  localparam logic [4:0] NOP_REG_ADDR = 5'b00000;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          err;
  logic [31:0]   rdata_q;

  logic        is_load;
  logic        is_store;
  logic        size_b;
  logic        size_h;
  logic        size_w;
  logic        sign_ext;
  logic        misaligned;
  logic        go;
  logic        req;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_result;
  logic [3:0]  st_sel;
  logic [31:0] st_data;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    size_b   = 1'b0;
    size_h   = 1'b0;
    size_w   = 1'b0;
    sign_ext = 1'b0;
    case (aluop_i)
      EXE_LB_OP:  begin is_load = 1'b1;  size_b = 1'b1; sign_ext = 1'b1; end
      EXE_LBU_OP: begin is_load = 1'b1;  size_b = 1'b1; end
      EXE_LH_OP:  begin is_load = 1'b1;  size_h = 1'b1; sign_ext = 1'b1; end
      EXE_LHU_OP: begin is_load = 1'b1;  size_h = 1'b1; end
      EXE_LW_OP:  begin is_load = 1'b1;  size_w = 1'b1; end
      EXE_SB_OP:  begin is_store = 1'b1; size_b = 1'b1; end
      EXE_SH_OP:  begin is_store = 1'b1; size_h = 1'b1; end
      EXE_SW_OP:  begin is_store = 1'b1; size_w = 1'b1; end
      default: ;
    endcase
  end

  assign misaligned = (size_h & mem_addr_i[0]) | (size_w & (|mem_addr_i[1:0]));
  assign go         = (is_load | is_store) & ~misaligned;
  // The request is live in IDLE and BUSY only; DONE presents the result with the bus idle.
  assign req        = rst & go & (state != DONE);
  assign cnt_inc    = cnt + CW'(1);

  // Big-endian lanes: address offset 0 is data[31:24].
  always_comb begin
    case (mem_addr_i[1:0])
      2'd0:    ld_byte = rdata_q[31:24];
      2'd1:    ld_byte = rdata_q[23:16];
      2'd2:    ld_byte = rdata_q[15:8];
      default: ld_byte = rdata_q[7:0];
    endcase
    ld_half = mem_addr_i[1] ? rdata_q[15:0] : rdata_q[31:16];
    if (size_b)
      ld_result = {{24{sign_ext & ld_byte[7]}}, ld_byte};
    else if (size_h)
      ld_result = {{16{sign_ext & ld_half[15]}}, ld_half};
    else
      ld_result = rdata_q;
  end

  always_comb begin
    st_sel  = 4'b1111;
    st_data = 32'h0;
    if (is_store) begin
      if (size_b) begin
        st_sel  = 4'b1000 >> mem_addr_i[1:0];
        st_data = {4{reg2_i[7:0]}};
      end else if (size_h) begin
        st_sel  = mem_addr_i[1] ? 4'b0011 : 4'b1100;
        st_data = {2{reg2_i[15:0]}};
      end else begin
        st_data = reg2_i;
      end
    end
  end

  // Ack only counts while the request is up; a timeout clears the captured data
  // so a timed-out load returns zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      err     <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            if (mem_ack_i) begin
              rdata_q <= mem_data_i;
              state   <= DONE;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt <= cnt_inc;
          if (mem_ack_i) begin
            rdata_q <= mem_data_i;
            state   <= DONE;
          end else if (cnt_inc == CW'(TIMEOUT)) begin
            rdata_q <= 32'h0;
            err     <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          cnt   <= '0;
          err   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    wd_o       = NOP_REG_ADDR;
    wreg_o     = 1'b0;
    wdata_o    = 32'h0;
    hi_o       = 32'h0;
    lo_o       = 32'h0;
    whilo_o    = 1'b0;
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_sel_o  = 4'b0000;
    mem_data_o = 32'h0;
    stallreq_o = 1'b0;
    addr_err_o = 1'b0;
    bus_err_o  = 1'b0;
    if (rst) begin
      wd_o       = wd_i;
      wreg_o     = wreg_i;
      wdata_o    = wdata_i;
      hi_o       = hi_i;
      lo_o       = lo_i;
      whilo_o    = whilo_i;
      addr_err_o = (is_load | is_store) & misaligned;
      if (is_store || ((is_load | is_store) && misaligned)) begin
        wreg_o = 1'b0;
      end else if (is_load) begin
        wdata_o = (state == DONE && !err) ? ld_result : 32'h0;
        if (state == DONE && err)
          wreg_o = 1'b0;
      end
      mem_req_o  = req;
      stallreq_o = req;
      bus_err_o  = (state == DONE) & err;
      if (req) begin
        mem_we_o   = is_store;
        mem_addr_o = {mem_addr_i[AW-1:2], 2'b00};
        mem_sel_o  = st_sel;
        mem_data_o = st_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: self-checking bench for mem_lsu (TIMEOUT=4).
//   Combinational vectors come from a table; bus transactions push their
//   expected result to a scoreboard queue that is popped when the stage
//   leaves the stall (DONE). Reset and timeout corner cases are hand-written.
`timescale 1ns/1ps
module tb_mem_lsu;

  localparam logic [7:0] OP_ADD = 8'b00100000;
  localparam logic [7:0] OP_OR  = 8'b00100101;
  localparam logic [7:0] OP_LB  = 8'b11100000;
  localparam logic [7:0] OP_LBU = 8'b11100100;
  localparam logic [7:0] OP_LH  = 8'b11100001;
  localparam logic [7:0] OP_LHU = 8'b11100101;
  localparam logic [7:0] OP_LW  = 8'b11100011;
  localparam logic [7:0] OP_SB  = 8'b11101000;
  localparam logic [7:0] OP_SH  = 8'b11101001;
  localparam logic [7:0] OP_SW  = 8'b11101011;
  localparam int TO = 4;
  localparam logic [31:0] HI_VAL = 32'hA5A50001;
  localparam logic [31:0] LO_VAL = 32'h5A5A0002;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic        whilo_i;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        whilo_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i;
  logic        mem_ack_i;
  logic        stallreq_o;
  logic        addr_err_o;
  logic        bus_err_o;

  always #5 clk = ~clk;

  mem_lsu #(.AW(32), .TIMEOUT(TO), .CW(16)) dut (
    .clk(clk), .rst(rst),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .hi_i(hi_i), .lo_i(lo_i), .whilo_i(whilo_i),
    .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_sel_o(mem_sel_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .stallreq_o(stallreq_o), .addr_err_o(addr_err_o), .bus_err_o(bus_err_o)
  );

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wreg;
    logic        exp_err;
    logic        exp_wreg;
    logic        chk_wdata;
  } vec_t;

  typedef struct {
    logic [31:0] wdata;
    logic        wreg;
    int          stalls;
    logic        err;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] data;
  } exp_t;

  vec_t vecs[8];
  exp_t sb_q[$];
  int   pass_count = 0;
  int   check_count = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic [7:0] op, input logic [31:0] addr,
                               input logic [31:0] rt, input logic [31:0] wdata, input logic wreg);
    aluop_i    = op;
    mem_addr_i = addr;
    reg2_i     = rt;
    wdata_i    = wdata;
    wreg_i     = wreg;
    wd_i       = 5'd9;
  endtask

  // Reference load: shift the addressed byte/halfword to the top, then extend.
  function automatic logic [31:0] model_load(input logic [7:0] op, input logic [31:0] addr,
                                             input logic [31:0] word);
    logic [31:0] sh;
    sh = word << (8 * addr[1:0]);
    case (op)
      OP_LB:   return {{24{sh[31]}}, sh[31:24]};
      OP_LBU:  return {24'h0, sh[31:24]};
      OP_LH:   return {{16{sh[31]}}, sh[31:16]};
      OP_LHU:  return {16'h0, sh[31:16]};
      default: return word;
    endcase
  endfunction

  function automatic logic [3:0] model_sel(input logic [7:0] op, input logic [31:0] addr);
    logic [3:0] s;
    int size;
    int a;
    s = 4'b0000;
    a = int'(addr[1:0]);
    size = (op == OP_SB) ? 1 : (op == OP_SH) ? 2 : 4;
    if (op != OP_SB && op != OP_SH && op != OP_SW) return 4'b1111;
    for (int i = 0; i < 4; i++)
      if (i >= a && i < a + size) s[3 - i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] model_sdata(input logic [7:0] op, input logic [31:0] rt);
    if (op == OP_SB) return {rt[7:0], rt[7:0], rt[7:0], rt[7:0]};
    if (op == OP_SH) return {rt[15:0], rt[15:0]};
    return rt;
  endfunction

  // One bus transaction; ack is raised in request cycle 'waits' (0-based).
  task automatic runMem(input string name, input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] rt, input logic [31:0] rdata, input int waits);
    exp_t e;
    exp_t got;
    bit   done;
    int   stalls;
    e.we     = (op == OP_SB || op == OP_SH || op == OP_SW);
    e.err    = (waits > TO);
    e.stalls = e.err ? TO + 1 : waits + 1;
    e.sel    = model_sel(op, addr);
    e.data   = model_sdata(op, rt);
    e.wdata  = (e.we || e.err) ? 32'h0 : model_load(op, addr, rdata);
    e.wreg   = !(e.we || e.err);
    sb_q.push_back(e);
    @(negedge clk);
    applyStimulus(op, addr, rt, 32'h0, 1'b1);
    mem_data_i = rdata;
    done = 0;
    stalls = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      #2;
      if (stallreq_o) begin
        stalls++;
        checkOutput({name, ".req"}, {31'h0, mem_req_o}, 32'h1);
        checkOutput({name, ".addr"}, mem_addr_o, {addr[31:2], 2'b00});
        checkOutput({name, ".sel"}, {28'h0, mem_sel_o}, {28'h0, e.sel});
        checkOutput({name, ".we"}, {31'h0, mem_we_o}, {31'h0, e.we});
        if (e.we) checkOutput({name, ".data"}, mem_data_o, e.data);
        mem_ack_i = (c == waits);
        @(negedge clk);
        mem_ack_i = 1'b0;
      end else begin
        done = 1;
        got = sb_q.pop_front();
        checkOutput({name, ".stalls"}, stalls, got.stalls);
        checkOutput({name, ".req_done"}, {31'h0, mem_req_o}, 32'h0);
        checkOutput({name, ".bus_err"}, {31'h0, bus_err_o}, {31'h0, got.err});
        checkOutput({name, ".wreg"}, {31'h0, wreg_o}, {31'h0, got.wreg});
        if (!got.we) checkOutput({name, ".wdata"}, wdata_o, got.wdata);
        checkOutput({name, ".hi"}, hi_o, HI_VAL);
        @(negedge clk);
        applyStimulus(OP_ADD, 32'h0, 32'h0, 32'h0, 1'b0);
        #2;
        checkOutput({name, ".bus_err_after"}, {31'h0, bus_err_o}, 32'h0);
        checkOutput({name, ".stall_after"}, {31'h0, stallreq_o}, 32'h0);
      end
    end
    if (!done) begin
      check_count++;
      $display("[TB] FAIL %s.complete: no DONE within 40 cycles, expected %0d stall cycles",
               name, e.stalls);
      void'(sb_q.pop_front());
      mem_ack_i = 1'b0;
    end
  endtask

  initial begin
    vecs[0] = '{OP_ADD, 32'h0,   32'h00001234, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{OP_OR,  32'h103, 32'hFFFF0000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{OP_LW,  32'h102, 32'h55,       1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{OP_LW,  32'h101, 32'h55,       1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{OP_LH,  32'h101, 32'h55,       1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{OP_LHU, 32'h103, 32'h55,       1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{OP_SH,  32'h101, 32'h55,       1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{OP_SW,  32'h103, 32'h55,       1'b1, 1'b1, 1'b0, 1'b0};

    rst = 1'b0;
    mem_ack_i = 1'b0;
    mem_data_i = 32'h0;
    hi_i = HI_VAL;
    lo_i = LO_VAL;
    whilo_i = 1'b1;
    applyStimulus(OP_ADD, 32'h0, 32'h0, 32'h1234, 1'b1);
    @(negedge clk);
    #2;
    checkOutput("reset.wd", {27'h0, wd_o}, 32'h0);
    checkOutput("reset.wreg", {31'h0, wreg_o}, 32'h0);
    checkOutput("reset.wdata", wdata_o, 32'h0);
    checkOutput("reset.hi", hi_o, 32'h0);
    checkOutput("reset.whilo", {31'h0, whilo_o}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i].op, vecs[i].addr, 32'hABCD5678, vecs[i].wdata, vecs[i].wreg);
      #2;
      checkOutput($sformatf("vec%0d.addr_err", i), {31'h0, addr_err_o}, {31'h0, vecs[i].exp_err});
      checkOutput($sformatf("vec%0d.req", i), {31'h0, mem_req_o}, 32'h0);
      checkOutput($sformatf("vec%0d.stall", i), {31'h0, stallreq_o}, 32'h0);
      checkOutput($sformatf("vec%0d.wreg", i), {31'h0, wreg_o}, {31'h0, vecs[i].exp_wreg});
      checkOutput($sformatf("vec%0d.wd", i), {27'h0, wd_o}, 32'd9);
      checkOutput($sformatf("vec%0d.lo", i), lo_o, LO_VAL);
      if (vecs[i].chk_wdata)
        checkOutput($sformatf("vec%0d.wdata", i), wdata_o, vecs[i].wdata);
    end

    // A stray ack with no request must not start anything.
    @(negedge clk);
    applyStimulus(OP_ADD, 32'h0, 32'h0, 32'h77, 1'b1);
    mem_ack_i = 1'b1;
    mem_data_i = 32'hFFFFFFFF;
    @(negedge clk);
    mem_ack_i = 1'b0;
    #2;
    checkOutput("stray_ack.stall", {31'h0, stallreq_o}, 32'h0);
    checkOutput("stray_ack.wdata", wdata_o, 32'h77);

    runMem("lb",    OP_LB,  32'h101, 32'h0,        32'h0080FF00, 0);
    runMem("lbu",   OP_LBU, 32'h101, 32'h0,        32'h0080FF00, 0);
    runMem("sh",    OP_SH,  32'h102, 32'hABCD5678, 32'h0,        3);
    runMem("lh",    OP_LH,  32'h100, 32'h0,        32'h80011234, 1);
    runMem("lhu",   OP_LHU, 32'h102, 32'h0,        32'hFFFF9ABC, 2);
    runMem("lw",    OP_LW,  32'h200, 32'h0,        32'hDEADBEEF, 2);
    runMem("sb",    OP_SB,  32'h203, 32'h11223344, 32'h0,        1);
    runMem("sw",    OP_SW,  32'h204, 32'hCAFEBABE, 32'h0,        0);
    runMem("lb_pos",OP_LB,  32'h100, 32'h0,        32'h7F000000, 0);
    runMem("lw_last", OP_LW, 32'h208, 32'h0,       32'h13579BDF, TO);
    runMem("lw_to", OP_LW,  32'h300, 32'h0,        32'h11111111, 99);

    // Reset in the middle of BUSY drops the request the same cycle.
    @(negedge clk);
    applyStimulus(OP_LW, 32'h400, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #2;
    checkOutput("rst_busy.req_before", {31'h0, mem_req_o}, 32'h1);
    rst = 1'b0;
    #1;
    checkOutput("rst_busy.req", {31'h0, mem_req_o}, 32'h0);
    checkOutput("rst_busy.stall", {31'h0, stallreq_o}, 32'h0);
    @(negedge clk);
    applyStimulus(OP_ADD, 32'h0, 32'h0, 32'h0, 1'b0);
    rst = 1'b1;
    runMem("lw_after_rst", OP_LW, 32'h404, 32'h0, 32'h2468ACE0, 1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
